// File: rtl/pwm_complement_capture.sv
// Complementary PWM pair monitor: measures high, dead-fall, low and dead-rise
// phases in clock cycles, reports their sum and flags shoot-through.
module pwm_complement_capture #(
  parameter int counter_bit_width = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         pwm_h_in,
  input  logic                         pwm_l_in,
  input  logic                         fault_clear,
  output logic [counter_bit_width-1:0] high_time,
  output logic [counter_bit_width-1:0] dead_time_fall,
  output logic [counter_bit_width-1:0] low_time,
  output logic [counter_bit_width-1:0] dead_time_rise,
  output logic [counter_bit_width+1:0] period_out,
  output logic                         valid,
  output logic                         timeout,
  output logic                         fault
);
  localparam int W = counter_bit_width;
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    H_ON  = 3'd1,
    DT_HL = 3'd2,
    L_ON  = 3'd3,
    DT_LH = 3'd4
  } state_t;

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] high_r;
  logic [W-1:0] dead_fall_r;
  logic [W-1:0] low_r;
  logic         h_meta, h_s, h_d;
  logic         l_meta, l_s, l_d;
  logic         h_rise, h_fall, l_fall, shoot;

  function automatic logic [W+1:0] widen(input logic [W-1:0] v);
    return {2'b00, v};
  endfunction

  // Two-flop synchronizers plus one delay stage per side for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_meta <= 1'b0;
      h_s    <= 1'b0;
      h_d    <= 1'b0;
      l_meta <= 1'b0;
      l_s    <= 1'b0;
      l_d    <= 1'b0;
    end else begin
      h_meta <= pwm_h_in;
      h_s    <= h_meta;
      h_d    <= h_s;
      l_meta <= pwm_l_in;
      l_s    <= l_meta;
      l_d    <= l_s;
    end
  end

  assign h_rise = h_s & ~h_d;
  assign h_fall = ~h_s & h_d;
  assign l_fall = ~l_s & l_d;
  assign shoot  = h_s & l_s & enable;

  // Phase FSM, phase counter and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= CNT_ZERO;
      high_r         <= CNT_ZERO;
      dead_fall_r    <= CNT_ZERO;
      low_r          <= CNT_ZERO;
      high_time      <= CNT_ZERO;
      dead_time_fall <= CNT_ZERO;
      low_time       <= CNT_ZERO;
      dead_time_rise <= CNT_ZERO;
      period_out     <= {(W+2){1'b0}};
      valid          <= 1'b0;
      timeout        <= 1'b0;
      fault          <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      if (shoot) begin
        fault <= 1'b1;
      end else if (fault_clear) begin
        fault <= 1'b0;
      end else begin
        fault <= fault;
      end

      if (!enable || shoot) begin
        state <= IDLE;
        cnt   <= CNT_ZERO;
      end else if (state != IDLE && cnt == CNT_MAX) begin
        timeout <= 1'b1;
        state   <= IDLE;
        cnt     <= CNT_ZERO;
      end else begin
        case (state)
          IDLE: begin
            if (h_rise) begin
              state <= H_ON;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= CNT_ZERO;
            end
          end
          H_ON: begin
            if (h_fall) begin
              high_r <= cnt;
              cnt    <= CNT_ONE;
              state  <= DT_HL;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          // Level tests let a same-cycle handover still register one DT cycle
          DT_HL: begin
            if (l_s) begin
              dead_fall_r <= cnt;
              cnt         <= CNT_ONE;
              state       <= L_ON;
            end else if (h_s) begin
              high_time      <= high_r;
              dead_time_fall <= cnt;
              low_time       <= CNT_ZERO;
              dead_time_rise <= CNT_ZERO;
              period_out     <= widen(high_r) + widen(cnt);
              valid          <= 1'b1;
              cnt            <= CNT_ONE;
              state          <= H_ON;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          L_ON: begin
            if (l_fall) begin
              low_r <= cnt;
              cnt   <= CNT_ONE;
              state <= DT_LH;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          DT_LH: begin
            if (h_s) begin
              high_time      <= high_r;
              dead_time_fall <= dead_fall_r;
              low_time       <= low_r;
              dead_time_rise <= cnt;
              period_out     <= widen(high_r) + widen(dead_fall_r) + widen(low_r) + widen(cnt);
              valid          <= 1'b1;
              cnt            <= CNT_ONE;
              state          <= H_ON;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/pwm_complement_capture.md
# pwm_complement_capture

Measures a complementary PWM pair (high-side / low-side gate signals) and reports per-cycle high time, low time, both dead-time gaps and total period in clock cycles. It also flags shoot-through (both sides on at once). It sits beside the complementary PWM generator as its loopback/monitor: it checks generator output in-system and in the bench, and it decodes externally supplied gate pairs.

## Interface
Parameters:
- `counter_bit_width`, default 16: width of each phase measurement counter and each phase result.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `enable`  in  1: measurement enable. When 0, FSM is held in IDLE.
- `pwm_h_in`  in  1: high-side gate signal. Asynchronous to `clk`.
- `pwm_l_in`  in  1: low-side gate signal. Asynchronous to `clk`.
- `fault_clear`  in  1: one-cycle request to clear `fault`.
- `high_time`  out  W: cycles `pwm_h` was high.
- `dead_time_fall`  out  W: cycles from `pwm_h` fall to `pwm_l` rise.
- `low_time`  out  W: cycles `pwm_l` was high.
- `dead_time_rise`  out  W: cycles from `pwm_l` fall to the next `pwm_h` rise.
- `period_out`  out  W+2: sum of the four phase results.
- `valid`  out  1: one-cycle pulse when all five results update together.
- `timeout`  out  1: one-cycle pulse when a phase counter saturates.
- `fault`  out  1: sticky shoot-through flag.

## Operation
- Each input passes through a 2-FF synchronizer, giving `h_s` / `l_s`. A further delay FF per signal feeds the edge detectors: rise = s & ~d, fall = ~s & d.
- FSM states are IDLE, H_ON, DT_HL, L_ON and DT_LH. There is one phase counter, `cnt`.
- IDLE: `cnt` is 0. An `h_s` rise moves to H_ON with `cnt`=1.
- H_ON: `cnt`++ each cycle. On `h_s` fall, latch `cnt` into the internal high register, set `cnt`=1 and move to DT_HL.
- DT_HL:
  - On `l_s` rise, latch the dead-fall register, set `cnt`=1 and move to L_ON.
  - On `h_s` rise (single-ended operation, low side disabled):
    - publish `high_time`;
    - set `dead_time_fall` = `cnt`, `low_time` = 0 and `dead_time_rise` = 0;
    - compute `period_out`, pulse `valid`;
    - set `cnt`=1 and move to H_ON.
- L_ON: `cnt`++. On `l_s` fall, latch the low register, set `cnt`=1 and move to DT_LH.
- DT_LH: `cnt`++. On `h_s` rise:
  - publish all four phase results and `period_out` = high + dead_fall + low + dead_rise (zero-extended, no overflow possible);
  - pulse `valid`;
  - set `cnt`=1 and move to H_ON. Measurement is back-to-back; no cycle is lost.
- Saturation: `cnt` reaching 2^W−1 in any non-IDLE state pulses `timeout`, goes to IDLE and publishes nothing.
- Shoot-through: `h_s` & `l_s` both 1 while `enable` is 1:
  - sets `fault`, goes to IDLE, publishes nothing;
  - while both stay high, the FSM stays in IDLE.
- `fault_clear` clears `fault`. If shoot-through is present in the same cycle, set wins.
- `enable` = 0:
  - FSM goes to IDLE and `cnt` to 0;
  - result outputs hold their last values;
  - `valid` and `timeout` are 0;
  - `fault` holds, and `fault_clear` still works;
  - synchronizers keep running.
- `enable` rising mid-waveform: the first `h_s` rise starts a measurement, so the first `valid` needs one full period.
- Unexpected edges are ignored: `l_s` edges in H_ON/DT_LH (other than shoot-through) and `h_s` edges in L_ON.

## Timing
- On `rst`, every output and internal register is 0: `high_time`, `dead_time_fall`, `low_time`, `dead_time_rise`, `period_out`, `valid`, `timeout`, `fault`, the FSM (=IDLE), `cnt` and the synchronizers.
- Pin-to-detect latency: 3 clock edges, counting the first edge that samples the new pin level as edge 1.
  - `valid`, the results and the state change are registered on edge 3.
  - `fault` and `timeout` use the same latency.
- All outputs are registered. `valid` is high for exactly 1 cycle. Results are stable from `valid` until the next `valid`.
- Phase values count clock cycles at synchronizer resolution. Both signals share the same synchronizer depth, so dead times are exact to ±1 cycle of pin asynchrony and exact for `clk`-synchronous stimulus.
- Minimum resolvable phase is 1 cycle. A 0-cycle dead time (one side falls while the other rises in the same sync cycle) is counted as 1 cycle in the departing state and 0 in DT. If DT_HL sees `l_s` rise on its entry cycle, it records `dead_time_fall` = 1.
- `rst` mid-measurement aborts immediately; no `valid` follows until a new full period completes.

## Test plan
- Synchronous stimulus, W=16: h high 20, gap 5, l high 30, gap 5, repeated 3×.
  - `valid` every 60 cycles.
  - `high_time`=20, `dead_time_fall`=5, `low_time`=30, `dead_time_rise`=5, `period_out`=60.
  - Check pin-to-`valid` latency is 3 edges.
- Single-ended: `pwm_l_in` held 0, h high 12 and low 8.
  - `high_time`=12, `dead_time_fall`=8, `low_time`=0, `dead_time_rise`=0, `period_out`=20.
- Shoot-through: force both inputs high for 4 cycles mid-L_ON.
  - `fault`=1 three edges later, no `valid`.
  - `fault_clear` while both are high: `fault` stays 1.
  - `fault_clear` after release: `fault` goes to 0 and the next full period gives `valid`.
- Timeout, W=8: hold h high 300 cycles.
  - `timeout` pulses once when `cnt` reaches 255, no `valid`, FSM in IDLE.
  - Next normal period measures correctly.
- Reset/enable: assert `rst` in DT_LH.
  - All outputs are 0 immediately.
  - Drop `enable` mid-H_ON: results hold, no `valid`.
  - Re-enable: first `valid` arrives only after a complete period.
- Loopback with the complementary generator, period=10, duty=4, dead_time=1.
  - Results match the analytic counts every cycle.
  - `fault` never asserts.
